// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch control states
//   FETCH_NOP     : instruction word placed in IF/ID for a bubble
//   INST_W_DEF    : default width of the instruction handed to decode
//   PC_STEP       : sequential PC increment
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_WAIT = 2'b01,
        S_HOLD = 2'b10,
        S_DROP = 2'b11
    } fetch_state_t;

    localparam int          INST_W_DEF = 26;
    localparam logic [31:0] FETCH_NOP  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP    = 32'd4;

    // Saturating increment used by the optional performance counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_stage_reg_fd.sv
// -----------------------------------------------------------------------------
// reg_fd
// IF/ID pipeline register. Flush has priority over load; with neither, the
// contents are held (valid_o is never cleared on its own).
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   load_i, flush_i     : load new instruction / load a bubble
//   inst_i, pc_plus8_i  : instruction and its PC+8
//   inst_o, pc_plus8_o, valid_o : registered IF/ID contents
// -----------------------------------------------------------------------------
import fetch_stage_pkg::*;

module reg_fd #(
    parameter int INST_W = INST_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic [31:0]       pc_plus8_i,
    output logic [INST_W-1:0] inst_o,
    output logic [31:0]       pc_plus8_o,
    output logic              valid_o
);

    localparam logic [INST_W-1:0] NOP_W = FETCH_NOP[INST_W-1:0];

    // IF/ID state: bubble on reset or flush, capture on load, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_o     <= NOP_W;
            pc_plus8_o <= 32'h0000_0000;
            valid_o    <= 1'b0;
        end else if (flush_i) begin
            inst_o     <= NOP_W;
            pc_plus8_o <= 32'h0000_0000;
            valid_o    <= 1'b0;
        end else if (load_i) begin
            inst_o     <= inst_i;
            pc_plus8_o <= pc_plus8_i;
            valid_o    <= 1'b1;
        end else begin
            inst_o     <= inst_o;
            pc_plus8_o <= pc_plus8_o;
            valid_o    <= valid_o;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: PC register, request/response control with at most one
// outstanding memory access, a one-entry hold buffer for words that return
// while decode is stalled, and the IF/ID register (reg_fd).
// Ports:
//   clk, reset                         : clock, asynchronous active-low reset
//   stall_d, flush_d                   : decode hold / bubble request
//   branch_taken_e, branch_target_e    : redirect from execute
//   imem_req, imem_addr, imem_gnt      : request channel
//   imem_rvalid, imem_rdata            : response channel
//   inst_d, pc_plus8_d, valid_d        : IF/ID outputs
//   perf_fetched, perf_bubbles         : only with FETCH_PERF_CNT_EN defined
// Build option: FETCH_PERF_CNT_EN adds saturating fetch/bubble counters.
// -----------------------------------------------------------------------------
import fetch_stage_pkg::*;

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          INST_W   = INST_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_d,
    input  logic              flush_d,
    input  logic              branch_taken_e,
    input  logic [31:0]       branch_target_e,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [INST_W-1:0] inst_d,
    output logic [31:0]       pc_plus8_d,
    output logic              valid_d
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubbles
`endif
);

    fetch_state_t      state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [INST_W-1:0] hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;
    // Low during reset and the cycle after release so imem_req stays quiet.
    logic              run_q;

    logic              fd_load_s;
    logic              fd_flush_s;
    logic [INST_W-1:0] fd_inst_s;
    logic [31:0]       fd_pc8_s;
    logic              gnt_s;
    logic              rdata_unused_s;

    assign gnt_s     = run_q && (state_q == S_REQ) && imem_gnt;
    assign imem_req  = run_q && (state_q == S_REQ);
    assign imem_addr = pc_q;
    // A redirect always replaces whatever decode would have received this cycle.
    assign fd_flush_s = flush_d || branch_taken_e;
    assign rdata_unused_s = ^{imem_rdata[31:INST_W], branch_target_e[1:0]};

    // Fetch state, PC and hold buffer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            hold_q     <= FETCH_NOP[INST_W-1:0];
            hold_vld_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            run_q      <= 1'b1;
        end
    end

    // Next-state, PC update and IF/ID load selection.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        fd_load_s  = 1'b0;
        fd_inst_s  = imem_rdata[INST_W-1:0];
        fd_pc8_s   = pc_q + PC_STEP + PC_STEP;

        if (branch_taken_e) begin
            pc_d       = {branch_target_e[31:2], 2'b00};
            hold_vld_d = 1'b0;
            // A request still in flight must have its response discarded.
            if (gnt_s || ((state_q == S_WAIT) && !imem_rvalid)) begin
                state_d = S_DROP;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (gnt_s) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        pc_d = pc_q + PC_STEP;
                        if (stall_d) begin
                            hold_d     = imem_rdata[INST_W-1:0];
                            hold_vld_d = 1'b1;
                            state_d    = S_HOLD;
                        end else begin
                            fd_load_s = 1'b1;
                            state_d   = S_REQ;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (!stall_d) begin
                        // PC already advanced past the held word.
                        fd_load_s  = hold_vld_q;
                        fd_inst_s  = hold_q;
                        fd_pc8_s   = pc_q + PC_STEP;
                        hold_vld_d = 1'b0;
                        state_d    = S_REQ;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DROP;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end
    end

    reg_fd #(
        .INST_W (INST_W)
    ) u_reg_fd (
        .clk        (clk),
        .reset      (reset),
        .load_i     (fd_load_s),
        .flush_i    (fd_flush_s),
        .inst_i     (fd_inst_s),
        .pc_plus8_i (fd_pc8_s),
        .inst_o     (inst_d),
        .pc_plus8_o (pc_plus8_d),
        .valid_o    (valid_d)
    );

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters of valid IF/ID loads and of bubble loads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= 32'h0000_0000;
            perf_bubbles <= 32'h0000_0000;
        end else if (fd_flush_s) begin
            perf_bubbles <= sat_inc32(perf_bubbles);
        end else if (fd_load_s) begin
            perf_fetched <= sat_inc32(perf_fetched);
        end else begin
            perf_fetched <= perf_fetched;
            perf_bubbles <= perf_bubbles;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Randomized bench with a transaction-level reference model of the fetch
// stage: expected request address, returned words awaiting decode, and the
// IF/ID contents are tracked as plain variables. A second instance checks
// PC wrap-around from a reset PC of 32'hFFFF_FFFC.
// -----------------------------------------------------------------------------
import fetch_stage_pkg::*;

module tb_fetch_stage;

    localparam int IW = INST_W_DEF;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          stall_d = 1'b0, flush_d = 1'b0, branch_taken_e = 1'b0;
    logic [31:0]   branch_target_e = 32'h0;
    logic          imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0]   imem_addr, imem_rdata = 32'h0;
    logic [IW-1:0] inst_d;
    logic [31:0]   pc_plus8_d;
    logic          valid_d;

    logic          w_req, w_gnt = 1'b0, w_rvalid = 1'b0, w_valid;
    logic [31:0]   w_addr, w_rdata = 32'h0, w_pc8;
    logic [IW-1:0] w_inst;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   perf_fetched, perf_bubbles, w_pf, w_pb;
`endif

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk(clk), .reset(reset), .stall_d(stall_d), .flush_d(flush_d),
        .branch_taken_e(branch_taken_e), .branch_target_e(branch_target_e),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_d(inst_d), .pc_plus8_d(pc_plus8_d), .valid_d(valid_d)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(reset), .stall_d(1'b0), .flush_d(1'b0),
        .branch_taken_e(1'b0), .branch_target_e(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .inst_d(w_inst), .pc_plus8_d(w_pc8), .valid_d(w_valid)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(w_pf), .perf_bubbles(w_pb)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0123_4567;
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0000;
    endfunction

    // memory responder state
    int          gnt_pct = 100, dly_min = 1, dly_max = 1;
    logic        mem_out = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    logic        stale = 1'b0;
    int          stale_cnt = 0;
    logic [31:0] stale_addr = 32'h0;

    // reference model state
    logic [31:0] m_pc;
    logic        m_drop, m_held, m_req, m_valid;
    logic [IW-1:0] m_hword, m_inst, nop_iw;
    logic [31:0] m_haddr, m_pc8;
    int          m_fetched, m_bub;

    task automatic model_reset();
        logic [31:0] nop32;
        nop32 = FETCH_NOP;
        nop_iw = nop32[IW-1:0];
        m_pc = 32'h0; m_drop = 1'b0; m_held = 1'b0; m_req = 1'b0;
        m_valid = 1'b0; m_inst = nop_iw; m_pc8 = 32'h0;
        m_fetched = 0; m_bub = 0;
    endtask

    task automatic step(input logic st, input logic fl, input logic br, input logic [31:0] tgt);
        logic rv, gn, ret_any, ret_ok, avail;
        logic [31:0] a, tmp, wpc;
        logic [IW-1:0] w, word;
        check_eq("req", 32'(imem_req), 32'(m_req));
        check_eq("valid", 32'(valid_d), 32'(m_valid));
        check_eq("inst", 32'(inst_d), 32'(m_inst));
        check_eq("pc8", pc_plus8_d, m_pc8);
        ret_any = mem_out && (mem_cnt == 1);
        rv = ret_any || (stale && stale_cnt == 1);
        gn = imem_req && !mem_out && !stale && ($urandom_range(99) < gnt_pct);
        if (gn) check_eq("addr", imem_addr, m_pc);
        stall_d = st; flush_d = fl; branch_taken_e = br; branch_target_e = tgt;
        imem_gnt = gn; imem_rvalid = rv;
        if (ret_any) imem_rdata = mem_word(mem_addr);
        else if (rv) imem_rdata = mem_word(stale_addr);
        else imem_rdata = $urandom;
        a = mem_addr;
        tmp = mem_word(a);
        w = tmp[IW-1:0];
        ret_ok = ret_any && !m_drop && !br;
        // responder bookkeeping
        if (mem_out) begin
            if (ret_any) begin mem_out = 1'b0; m_drop = 1'b0; end
            else begin mem_cnt--; if (br) m_drop = 1'b1; end
        end
        if (gn) begin
            mem_out = 1'b1; mem_cnt = $urandom_range(dly_max, dly_min); mem_addr = imem_addr;
            if (br) m_drop = 1'b1;
        end
        if (stale) begin
            if (stale_cnt == 1) stale = 1'b0; else stale_cnt--;
        end
        // next fetch address
        if (br) begin m_pc = {tgt[31:2], 2'b00}; m_held = 1'b0; end
        else if (ret_ok) m_pc = a + 32'd4;
        // delivery of the oldest surviving word to decode
        avail = !br && (m_held || ret_ok);
        word = m_held ? m_hword : w;
        wpc = m_held ? m_haddr : a;
        if (avail && !st) begin
            m_held = 1'b0;
            if (!fl) begin m_inst = word; m_pc8 = wpc + 32'd8; m_valid = 1'b1; m_fetched++; end
        end else if (ret_ok) begin
            m_held = 1'b1; m_hword = w; m_haddr = a;
        end
        if (fl || br) begin m_inst = nop_iw; m_pc8 = 32'h0; m_valid = 1'b0; m_bub++; end
        m_req = !mem_out && !m_held;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        stall_d = 1'b0; flush_d = 1'b0; branch_taken_e = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        #1;
        check_eq("rst_req", 32'(imem_req), 32'h0);
        check_eq("rst_valid", 32'(valid_d), 32'h0);
        check_eq("rst_inst", 32'(inst_d), FETCH_NOP & 32'h03FF_FFFF);
        check_eq("rst_pc8", pc_plus8_d, 32'h0);
        if (mem_out) begin
            stale = 1'b1; stale_cnt = mem_cnt; stale_addr = mem_addr; mem_out = 1'b0;
        end
        model_reset();
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); @(negedge clk);
            check_eq("rst_req_hold", 32'(imem_req), 32'h0);
        end
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] tmp;
        logic st, fl, br, did_rst;
        logic [31:0] tgt;
        did_rst = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset(3);

        // first fetch: grant in the first requesting cycle, data one cycle later
        gnt_pct = 100; dly_min = 1; dly_max = 1;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("first_inst", 32'(inst_d), 32'h0123_4567);
        check_eq("first_pc8", pc_plus8_d, 32'h8);
        check_eq("first_valid", 32'(valid_d), 32'h1);

        // word returns while decode stalls for three cycles
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("hold_req", 32'(imem_req), 32'h0);
        check_eq("hold_inst", 32'(inst_d), 32'h0123_4567);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("hold_req2", 32'(imem_req), 32'h0);
        check_eq("hold_inst2", 32'(inst_d), 32'h0123_4567);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        tmp = mem_word(32'h4);
        check_eq("held_inst", 32'(inst_d), tmp & 32'h03FF_FFFF);
        check_eq("held_pc8", pc_plus8_d, 32'hC);
        check_eq("after_hold_addr", imem_addr, 32'h8);

        // redirect while waiting for data
        dly_min = 2; dly_max = 2;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h103);
        check_eq("br_valid", 32'(valid_d), 32'h0);
        check_eq("br_req", 32'(imem_req), 32'h0);
        dly_min = 1; dly_max = 1;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("drop_valid", 32'(valid_d), 32'h0);
        check_eq("br_addr", imem_addr, 32'h100);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("br_inst_pc8", pc_plus8_d, 32'h108);

        // flush together with stall
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("flush_inst", 32'(inst_d), FETCH_NOP & 32'h03FF_FFFF);
        check_eq("flush_valid", 32'(valid_d), 32'h0);

        // randomized traffic with one reset while a request is outstanding
        for (int i = 0; i < 4000; i++) begin
            gnt_pct = 70; dly_min = 1; dly_max = 3;
            if (i >= 2000 && !did_rst && mem_out) begin
                did_rst = 1'b1;
                do_reset(2);
                gnt_pct = 0;
                for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 32'h0);
                check_eq("late_rvalid_valid", 32'(valid_d), 32'h0);
                check_eq("late_rvalid_addr", imem_addr, 32'h0);
                gnt_pct = 70;
            end
            st = ($urandom_range(99) < 25);
            fl = ($urandom_range(99) < 8);
            br = !m_drop && ($urandom_range(99) < 6);
            tgt = (i % 5 == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(3))) : $urandom;
            step(st, fl, br, tgt);
        end
        check_eq("mid_reset_done", 32'(did_rst), 32'h1);
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_fetched", perf_fetched, 32'(m_fetched));
        check_eq("perf_bubbles", perf_bubbles, 32'(m_bub));
`endif

        // wrap-around instance, idling in its request state since reset
        check_eq("wrap_req", 32'(w_req), 32'h1);
        check_eq("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        w_gnt = 1'b1;
        @(posedge clk); @(negedge clk);
        w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'hDEAD_BEEF;
        @(posedge clk); @(negedge clk);
        w_rvalid = 1'b0;
        check_eq("wrap_valid", 32'(w_valid), 32'h1);
        check_eq("wrap_inst", 32'(w_inst), 32'h02AD_BEEF);
        check_eq("wrap_pc8", w_pc8, 32'h0000_0004);
        check_eq("wrap_addr1", w_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check_eq("wrap_perf_fetched", w_pf, 32'h1);
        check_eq("wrap_perf_bubbles", w_pb, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
